// File: rtl/mips_pkg.sv
// Shared types and sizing for the unified-memory port arbiter.
package mips_pkg;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int STARVE_MAX_DEF = 3;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_M  = 3'd2,
    RESP_IF = 3'd3,
    RESP_M  = 3'd4
  } arb_state_t;
endpackage

// File: rtl/arb_watchdog.sv
// 8-bit BUSY-cycle counter; expired marks the TIMEOUT-th consecutive busy cycle.
module arb_watchdog
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;

  // cnt_q holds the number of busy cycles already elapsed, so it equals
  // TIMEOUT-1 during the TIMEOUT-th one.
  assign expired = en && (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and M-stage traffic onto one single-port memory and
// produces the stalls consumed by the hazard unit.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              m_read,
  input  logic              m_write,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_m,
  output logic              mem_err
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              kill_q, kill_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, m_rdata_q, m_rdata_d;
  logic              if_valid_q, if_valid_d, m_valid_q, m_valid_d;
  logic              err_q, err_d;
  logic              m_pend, busy, wd_expired, if_wins;

  assign m_pend  = m_read | m_write;
  assign busy    = (state_q == BUSY_IF) || (state_q == BUSY_M);
  assign if_wins = if_req && (!m_pend || (starve_q == SW'(STARVE_MAX)));

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clr    (!busy),
    .en     (busy),
    .expired(wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    kill_d     = kill_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    m_rdata_d  = m_rdata_q;
    if_valid_d = 1'b0;
    m_valid_d  = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (if_wins) begin
          state_d  = BUSY_IF;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          starve_d = '0;
          kill_d   = if_kill;
        end else if (m_pend) begin
          state_d = BUSY_M;
          req_d   = 1'b1;
          we_d    = m_write;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          if (if_req && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
        end
      end
      BUSY_IF, BUSY_M: begin
        if (state_q == BUSY_IF && if_kill) kill_d = 1'b1;
        if (mem_ready || wd_expired) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          // A ready in the expiring cycle still wins: the data is good.
          if (!mem_ready) err_d = 1'b1;
          if (state_q == BUSY_IF) begin
            state_d    = RESP_IF;
            if_rdata_d = mem_ready ? mem_rdata : '0;
            if_valid_d = !(kill_q || if_kill);
          end else begin
            state_d   = RESP_M;
            m_rdata_d = (mem_ready && !we_q) ? mem_rdata : '0;
            m_valid_d = 1'b1;
          end
        end
      end
      RESP_IF: state_d = IDLE;
      RESP_M:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      m_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      m_rdata_q  <= m_rdata_d;
      if_valid_q <= if_valid_d;
      m_valid_q  <= m_valid_d;
      err_q      <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign m_rdata   = m_rdata_q;
  assign if_valid  = if_valid_q;
  assign m_valid   = m_valid_q;
  assign mem_err   = err_q;

  // if_valid is registered, so a kill landing in RESP_IF is honoured by
  // keeping the fetch stalled rather than by retracting the pulse.
  assign stall_m  = m_pend & ~m_valid_q;
  assign stall_if = (if_req & ~(if_valid_q & ~(kill_q | if_kill))) | stall_m;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-schedule reference model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset;
  logic        if_req, if_kill, if_valid, m_read, m_write, m_valid;
  logic [31:0] if_addr, if_rdata, m_addr, m_wdata, m_rdata;
  logic        mem_req, mem_we, mem_ready, stall_if, stall_m, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int checks = 0, errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid), .m_read(m_read), .m_write(m_write),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_valid(m_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_if(stall_if), .stall_m(stall_m),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic idle_in();
    if_req = 0; if_addr = 0; if_kill = 0; m_read = 0; m_write = 0;
    m_addr = 0; m_wdata = 0; mem_rdata = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    idle_in(); reset = 1; cyc(); cyc();
    checks++; if ({mem_req, mem_we, if_valid, m_valid, mem_err, stall_if, stall_m} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 0000000", {mem_req, mem_we, if_valid, m_valid, mem_err, stall_if, stall_m}); end
    checks++; if ({mem_addr, mem_wdata, if_rdata, m_rdata} !== 128'b0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, if_rdata, m_rdata}); end
    reset = 0; cyc();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_idle mem_req got %b exp 0", mem_req); end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h40; #1;
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %b exp 1", stall_if); end
    cyc();
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h40}) begin
      errors++; $display("FAIL fetch_req_c1 got %b%b %h exp 10 00000040", mem_req, mem_we, mem_addr); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1 got %b exp 1", stall_if); end
    mem_ready = 1; mem_rdata = 32'h2008_0005; cyc();
    checks++; if ({if_valid, mem_req, if_rdata} !== {2'b10, 32'h2008_0005}) begin
      errors++; $display("FAIL fetch_valid_c2 got %b%b %h exp 10 20080005", if_valid, mem_req, if_rdata); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fetch_stall_c2 got %b exp 0", stall_if); end
    mem_ready = 0; if_req = 0; cyc();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b exp 0", if_valid); end
  endtask

  task automatic test_store_then_fetch();
    if_req = 1; if_addr = 32'h80; m_write = 1; m_addr = 32'h100; m_wdata = 32'hDEAD_BEEF; #1;
    checks++; if ({stall_m, stall_if} !== 2'b11) begin errors++; $display("FAIL st_stall_c0 got %b exp 11", {stall_m, stall_if}); end
    cyc();
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h100, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL st_grant got %b%b %h %h exp 11 00000100 deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
    mem_ready = 1; cyc();
    checks++; if ({m_valid, mem_req, mem_we, if_valid} !== 4'b1000) begin
      errors++; $display("FAIL st_done got %b exp 1000", {m_valid, mem_req, mem_we, if_valid}); end
    mem_ready = 0; m_write = 0; cyc();
    checks++; if ({stall_m, m_valid} !== 2'b00) begin errors++; $display("FAIL st_stall_after got %b exp 00", {stall_m, m_valid}); end
    cyc();
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h80}) begin
      errors++; $display("FAIL st_if_grant got %b%b %h exp 10 00000080", mem_req, mem_we, mem_addr); end
    mem_ready = 1; mem_rdata = 32'h0000_1234; cyc();
    checks++; if ({if_valid, if_rdata} !== {1'b1, 32'h1234}) begin
      errors++; $display("FAIL st_if_data got %b %h exp 1 00001234", if_valid, if_rdata); end
    mem_ready = 0; if_req = 0; cyc();
  endtask

  task automatic test_starvation();
    logic [7:0] exp_m = 8'b0111_0111;
    if_req = 1; if_addr = 32'h200; m_read = 1; m_addr = 32'h300;
    for (int g = 0; g < 8; g++) begin
      int n = 0;
      logic is_m;
      while (!mem_req && n < 20) begin cyc(); n++; end
      checks++; if (!mem_req) begin errors++; $display("FAIL starve_wait grant %0d got no mem_req exp mem_req", g); end
      is_m = (mem_addr == 32'h300);
      checks++; if (is_m !== exp_m[g]) begin errors++; $display("FAIL starve_order grant %0d got M=%b exp M=%b", g, is_m, exp_m[g]); end
      mem_ready = 1; mem_rdata = 32'h1111_0000 + 32'(g); cyc();
      mem_ready = 0;
      checks++; if ({m_valid, if_valid} !== (is_m ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL starve_valid grant %0d got %b exp %b", g, {m_valid, if_valid}, is_m ? 2'b10 : 2'b01); end
      if (g == 7) begin if_req = 0; m_read = 0; end
      cyc();
    end
  endtask

  task automatic test_kill();
    if_req = 1; if_addr = 32'h44; cyc();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL kill_req got %b exp 1", mem_req); end
    if_kill = 1; cyc(); if_kill = 0; cyc();
    mem_ready = 1; mem_rdata = 32'hBAD0_BAD0; cyc();
    checks++; if ({if_valid, mem_req} !== 2'b00) begin errors++; $display("FAIL kill_suppress got %b exp 00", {if_valid, mem_req}); end
    mem_ready = 0; if_addr = 32'h80; #1;
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL kill_stall got %b exp 1", stall_if); end
    cyc(); cyc();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL kill_refetch got %b %h exp 1 00000080", mem_req, mem_addr); end
    mem_ready = 1; mem_rdata = 32'h0000_CAFE; cyc();
    checks++; if ({if_valid, if_rdata} !== {1'b1, 32'hCAFE}) begin
      errors++; $display("FAIL kill_next_data got %b %h exp 1 0000cafe", if_valid, if_rdata); end
    mem_ready = 0; if_req = 0; cyc();
  endtask

  task automatic test_timeout();
    int n = 0;
    m_read = 1; m_addr = 32'h10; mem_rdata = 32'h5555_AAAA; cyc();
    checks++; if ({mem_req, mem_err} !== 2'b10) begin errors++; $display("FAIL to_start got %b exp 10", {mem_req, mem_err}); end
    while (mem_req && n < 400) begin cyc(); n++; end
    checks++; if (n !== 255) begin errors++; $display("FAIL to_busy_cycles got %0d exp 255", n); end
    checks++; if ({m_valid, mem_err, m_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL to_abort got %b%b %h exp 11 00000000", m_valid, mem_err, m_rdata); end
    m_read = 0; cyc(); cyc();
    checks++; if ({mem_err, m_valid} !== 2'b10) begin errors++; $display("FAIL to_sticky got %b exp 10", {mem_err, m_valid}); end
  endtask

  task automatic test_reset_mid();
    m_read = 1; m_addr = 32'h20; cyc();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req got %b exp 1", mem_req); end
    reset = 1; cyc();
    checks++; if ({mem_req, mem_we, m_valid, if_valid, mem_err, mem_addr, m_rdata} !== 69'b0) begin
      errors++; $display("FAIL rst_mid_clear got %b%b%b%b%b %h %h exp all 0", mem_req, mem_we, m_valid, if_valid, mem_err, mem_addr, m_rdata); end
    reset = 0; m_read = 0; mem_ready = 1; cyc();
    checks++; if ({m_valid, mem_req} !== 2'b00) begin errors++; $display("FAIL rst_mid_novalid got %b exp 00", {m_valid, mem_req}); end
    mem_ready = 0; if_req = 1; if_addr = 32'h48; cyc();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h48}) begin
      errors++; $display("FAIL rst_mid_idle got %b %h exp 1 00000048", mem_req, mem_addr); end
    mem_ready = 1; cyc(); mem_ready = 0; if_req = 0; cyc();
  endtask

  // Reference model: grants happen in the first cycle the bus is free and a
  // requester is pending; the winner follows the starvation rule; valid is
  // due one cycle after ready; the bus is free again two cycles after ready.
  task automatic test_random();
    logic [31:0] mem [16];
    int starve = 0, next_free = 0;
    bit busy = 0, owner_m = 0, t_we = 0, e_req = 0, e_ifv = 0, e_mv = 0, e_sm, e_si;
    logic [31:0] t_addr = 0, t_wdata = 0, e_ifd = 0, e_md = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    idle_in(); reset = 1; cyc(); reset = 0;
    for (int c = 0; c < 600; c++) begin
      if (!if_req || if_valid) begin
        if_req = ($urandom_range(0, 3) != 0); if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!(m_read || m_write) || m_valid) begin
        int op = $urandom_range(0, 3);
        m_read = (op == 1 || op == 2); m_write = (op == 3);
        m_addr = 32'($urandom_range(0, 15)) << 2; m_wdata = $urandom;
      end
      mem_ready = mem_req && ($urandom_range(0, 2) == 0);
      mem_rdata = mem_ready ? mem[mem_addr[5:2]] : $urandom;
      #1;
      e_sm = (m_read | m_write) & ~e_mv;
      e_si = (if_req & ~e_ifv) | e_sm;
      checks++; if (mem_req !== e_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", c, mem_req, e_req); end
      if (e_req) begin
        checks++; if ({mem_addr, mem_we} !== {t_addr, t_we}) begin
          errors++; $display("FAIL rnd_addr cyc %0d got %h/%b exp %h/%b", c, mem_addr, mem_we, t_addr, t_we); end
        if (t_we) begin
          checks++; if (mem_wdata !== t_wdata) begin errors++; $display("FAIL rnd_wdata cyc %0d got %h exp %h", c, mem_wdata, t_wdata); end
        end
      end
      checks++; if ({if_valid, m_valid} !== {e_ifv, e_mv}) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b%b exp %b%b", c, if_valid, m_valid, e_ifv, e_mv); end
      if (e_ifv) begin
        checks++; if (if_rdata !== e_ifd) begin errors++; $display("FAIL rnd_ifdata cyc %0d got %h exp %h", c, if_rdata, e_ifd); end
      end
      if (e_mv) begin
        checks++; if (m_rdata !== e_md) begin errors++; $display("FAIL rnd_mdata cyc %0d got %h exp %h", c, m_rdata, e_md); end
      end
      checks++; if ({stall_if, stall_m} !== {e_si, e_sm}) begin
        errors++; $display("FAIL rnd_stall cyc %0d got %b%b exp %b%b", c, stall_if, stall_m, e_si, e_sm); end
      e_ifv = 0; e_mv = 0;
      if (e_req && mem_ready) begin
        e_req = 0; busy = 0; next_free = c + 2;
        if (!owner_m) begin e_ifv = 1; e_ifd = mem[t_addr[5:2]]; end
        else begin
          e_mv = 1; e_md = t_we ? 32'h0 : mem[t_addr[5:2]];
          if (t_we) mem[t_addr[5:2]] = t_wdata;
        end
      end else if (!busy && c >= next_free && (if_req || m_read || m_write)) begin
        busy = 1; e_req = 1;
        if (if_req && (!(m_read || m_write) || starve == 3)) begin
          owner_m = 0; t_addr = if_addr; t_we = 0; starve = 0;
        end else begin
          owner_m = 1; t_addr = m_addr; t_we = m_write; t_wdata = m_wdata;
          if (if_req && starve < 3) starve++;
        end
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_then_fetch();
    test_starvation();
    test_kill();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: instruction fetch (IF, read-only) and the memory stage (M, load/store).
- M-stage inputs come from the EX/MEM pipeline register outputs: address, store data, write enable, load enable.
- Sequences each variable-latency memory transaction and produces the stall signals consumed by the hazard unit.
- Provides fairness against IF starvation and a watchdog so a dead memory cannot hang the pipeline.

Parameters:
- STARVE_MAX, 3: consecutive M grants with IF pending before IF is forced to win one arbitration.
- TIMEOUT, 255: BUSY cycles without mem_ready before the transaction is aborted (8-bit counter).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  IF wants an instruction word
- if_addr  in  32  fetch address
- if_kill  in  1  branch redirect; discard the outstanding IF result
- if_rdata  out  32  fetched word, valid with if_valid
- if_valid  out  1  one-cycle pulse
- m_read  in  1  M-stage load (MemToRegM)
- m_write  in  1  M-stage store (MemWriteM)
- m_addr  in  32  ALUOutM
- m_wdata  in  32  WriteDataM
- m_rdata  out  32  load data, valid with m_valid
- m_valid  out  1  one-cycle pulse, completion of load or store
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write strobe
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_ready  in  1  transaction completes this cycle
- stall_if  out  1  hold PC and IF/ID register
- stall_m  out  1  hold the whole pipeline up to and including EX/MEM
- mem_err  out  1  sticky timeout flag

Behaviour:
- State machine states: IDLE, BUSY_IF, BUSY_M, RESP_IF, RESP_M.
- Outputs mem_*, if_valid, m_valid, if_rdata, m_rdata and mem_err are registered.
- stall_if and stall_m are combinational.
- Reset values: state IDLE, every output 0 (including mem_err), starve_cnt 0, timeout counter 0, kill flag 0.
- Reset mid-transaction abandons it: mem_req drops the next edge and no valid pulse is generated.

IDLE arbitration (m_pend = m_read | m_write):
- M wins if m_pend, except when if_req and starve_cnt == STARVE_MAX; then IF wins.
- On grant, latch addr, we (m_write for M, 0 for IF) and wdata onto the mem_* outputs, set mem_req = 1, and go to BUSY_x on the next edge.
- M granted while if_req is high: starve_cnt += 1, saturating at STARVE_MAX.
- IF granted: starve_cnt = 0.

BUSY_x:
- mem_req and mem_* are held stable.
- On mem_ready: mem_req <= 0, capture mem_rdata into x_rdata (for a store, m_rdata <= 0), go to RESP_x.
- Timeout counter increments each BUSY cycle. On reaching TIMEOUT: mem_err <= 1, mem_req <= 0, x_rdata <= 0, go to RESP_x.

RESP_x:
- x_valid = 1 for this single cycle, then IDLE.
- No grant is made in RESP, so the completing M instruction is never re-issued.

Latency:
- Request seen at cycle 0, mem_req high at cycle 1; mem_ready at cycle 1 gives valid at cycle 2.
- Next grant no earlier than cycle 3.

if_kill:
- Asserted during BUSY_IF or RESP_IF (or in the granting IDLE cycle): the transaction completes on the bus, but if_valid is suppressed.
- Kill flag clears on return to IDLE.

Stalls:
- stall_m = m_pend & ~m_valid.
- stall_if = (if_req & ~(if_valid & ~kill)) | stall_m.

Ordering and writes:
- Simultaneous m_valid and new if_req: no conflict; the next IDLE arbitrates normally.
- Store sets mem_we = 1 only while mem_req is high.

Decomposition:
- Shared package mips_pkg: state encoding enum (arb_state_t), ADDR_W = 32, DATA_W = 32, defaults for STARVE_MAX and TIMEOUT.
- One natural sub-module: arb_watchdog (8-bit timeout counter with clear/enable/expired).
- Arbitration and FSM stay in the top module.

Test Plan:
1. Only if_req = 1, if_addr = 0x0000_0040, mem_ready on the first BUSY cycle with mem_rdata = 0x2008_0005 -> mem_req at cycle 1, if_valid = 1 with if_rdata = 0x2008_0005 at cycle 2, stall_if high for cycles 0-1.
2. Simultaneous if_req and m_write (m_addr = 0x100, m_wdata = 0xDEAD_BEEF) -> M granted first with mem_we = 1 and mem_wdata = 0xDEAD_BEEF, m_valid pulse, then IF granted; stall_m low the cycle after m_valid.
3. m_read held for 5 back-to-back loads with if_req always high, STARVE_MAX = 3 -> grant order M, M, M, IF, M; starve_cnt returns to 0 after the IF grant.
4. IF in BUSY_IF, if_kill pulsed, mem_ready 2 cycles later -> no if_valid pulse; the following fetch proceeds normally.
5. mem_ready never asserted on an M load -> after 255 BUSY cycles mem_err = 1 and m_valid pulses with m_rdata = 0; mem_err stays 1 until reset.
6. reset asserted during BUSY_M -> next edge: mem_req = 0, state IDLE, no m_valid, all outputs 0.
